rng_server: RTL
===============

// Module: rng_server
// PURPOSE
// Shares one Fibonacci LFSR random source among N requesters. Grants are round-robin, one per cycle,
// and each grant delivers a unique sample. Sequences seeding, warm-up and runtime reseed of the LFSR.
// Sits between the RNG datapath and consumers (test-pattern generators, randomized schedulers).
// PARAMETERS
// WIDTH          8   LFSR/sample width; legal values 8, 16, 32 only (elaboration error otherwise)
// N_REQ          4   number of requesters, 1..16
// WARMUP_CYCLES  16  LFSR steps discarded after every (re)seed, 0..255; 0 = serve immediately
// PORTS
// clk           in   1           rising-edge clock
// reset         in   1           synchronous, active-high
// seed          in   WIDTH       seed sampled on reset
// reseed        in   1           single-cycle pulse: load reseed_value
// reseed_value  in   WIDTH       seed sampled when reseed=1
// req           in   N_REQ       per-requester request level; held until its gnt
// gnt           out  N_REQ       one-hot grant pulse, registered
// rnd_valid     out  1           high with any gnt bit
// rnd_out       out  WIDTH       sample for the granted requester; valid only with rnd_valid
// ready         out  1           high in SERVE state
// BEHAVIOUR
// - One clock, synchronous active-high reset. On reset: gnt=0, rnd_valid=0, rnd_out=0, ready=0,
//   rr pointer=0, lfsr<=sanitize(seed), warm-up counter<=WARMUP_CYCLES.
//   State goes to WARMUP, or to SERVE if WARMUP_CYCLES==0.
// - sanitize(x): if x==0 or x has any X/Z bit, use {WIDTH/8{8'hAA}}; otherwise use x.
// - LFSR step (shift right, new MSB = XOR of taps):
//   WIDTH 8 -> b7^b5^b4^b3; 16 -> b15^b13^b12^b10; 32 -> b31^b21^b1^b0.
//   Next = {fb, lfsr[WIDTH-1:1]}. If lfsr is all-zero or X at step time, next = sanitize(0).
// - States:
//   WARMUP: LFSR steps every cycle; counter decrements; gnt=0; ready=0.
//     Counter 0 -> SERVE next cycle. After K steps the first served sample is K steps past the seed.
//   SERVE: ready=1. The LFSR steps only on cycles a grant is issued.
// - Grant: in SERVE with |req and no reseed, pick the first set req at or above rr pointer (wrapping).
//   Next cycle: gnt[i]=1, rnd_valid=1, rnd_out=the pre-step lfsr value. rr pointer <= (i+1)%N_REQ.
//   Latency req->gnt is 1 cycle. At most one grant per cycle.
//   A req still high the cycle after its gnt is a new request.
// - Sustained all-ones req: gnt rotates 0,1,..,N-1,0. Each requester waits at most N_REQ-1 grants.
// - reseed=1 in any state (not reset): lfsr<=sanitize(reseed_value), counter reloaded,
//   state goes to WARMUP (SERVE if WARMUP_CYCLES==0). No grant is issued in that cycle.
//   The rr pointer is kept. A reseed during WARMUP restarts warm-up.
// - reset and reseed in the same cycle: reset wins. reseed and req in the same cycle: reseed wins,
//   req is not consumed.
// - gnt, rnd_valid and rnd_out are all registered. gnt/rnd_valid are 0 in every cycle without a grant.
//   rnd_out holds its last value.
// STRUCTURE
// - Package rng_pkg: typedef enum {WARMUP, SERVE} rng_state_t.
//   Also holds AA_PATTERN and the per-WIDTH tap-mask constants (8'hB8, 16'hB400, 32'h80200003).
// - Sub-module rr_arbiter #(N): req, enable, pointer in -> one-hot grant, next pointer (combinational).
// - LFSR step and sanitize are functions in rng_pkg, shared with the standalone RNG.
// TESTING
// 1 WIDTH=8, WARMUP=0, seed 8'h80, req0 held:
//   rnd_out 8'h80, 8'hC0, 8'hE0, 8'h70 on consecutive gnt[0] cycles.
// 2 seed 8'h00 (and seed 8'hxx) -> first served sample 8'hAA; never 8'h00.
// 3 N_REQ=4, req=4'b1111 held -> gnt 0001,0010,0100,1000,0001.
//   All rnd_out values distinct, consecutive LFSR states.
// 4 WARMUP=3, seed 8'h80 -> ready rises after 3 cycles; first sample 8'h70. No gnt while ready=0.
// 5 reseed 8'h80 while req=4'b0101 in SERVE -> no gnt that cycle; rr pointer kept.
//   After warm-up, sequence restarts from 8'h80 stepped WARMUP times.
// 6 reset asserted together with reseed and req mid-traffic -> all outputs 0 next cycle;
//   lfsr=sanitize(seed); pointer=0.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared RNG definitions: server state type, LFSR tap masks, and the
// width-generic LFSR step / seed sanitize helpers.
package rng_pkg;

    typedef enum logic {WARMUP, SERVE} rng_state_t;

    localparam logic [31:0] AA_PATTERN = 32'hAAAA_AAAA;
    localparam logic [7:0]  TAPS_8     = 8'hB8;
    localparam logic [15:0] TAPS_16    = 16'hB400;
    localparam logic [31:0] TAPS_32    = 32'h8020_0003;

    function automatic logic [31:0] width_mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] tap_mask(input int w);
        case (w)
            8:       return 32'(TAPS_8);
            16:      return 32'(TAPS_16);
            default: return TAPS_32;
        endcase
    endfunction

    // Zero or unknown seeds would lock the LFSR, so they map to the AA pattern.
    function automatic logic [31:0] sanitize(input logic [31:0] x, input int w);
        logic [31:0] m;
        m = x & width_mask(w);
        if ($isunknown(m) || (m == 32'd0))
            return AA_PATTERN & width_mask(w);
        return m;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] x, input int w);
        logic [31:0] m;
        logic        fb;
        m = x & width_mask(w);
        if ($isunknown(m) || (m == 32'd0))
            return sanitize(32'd0, w);
        fb = ^(m & tap_mask(w));
        return (32'(fb) << (w - 1)) | (m >> 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: first request at or above the pointer wins,
// wrapping; also returns the pointer to use after that grant.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic          i_enable,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_next_ptr
);

    always_comb begin
        int   idx;
        logic found;
        o_gnt      = '0;
        o_next_ptr = i_ptr;
        found      = 1'b0;
        idx        = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(i_ptr) + k) % N;
            if (i_enable && !found && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                o_next_ptr = PW'((idx + 1) % N);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_server.sv
// Shares one Fibonacci LFSR among N_REQ requesters: seeding and warm-up
// sequencing, runtime reseed, and round-robin delivery of unique samples.
module rng_server
    import rng_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int N_REQ         = 4,
    parameter int WARMUP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed,
    input  logic             reseed,
    input  logic [WIDTH-1:0] reseed_value,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             rnd_valid,
    output logic [WIDTH-1:0] rnd_out,
    output logic             ready
);

    localparam int              PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0]      WARM_INIT = 8'(WARMUP_CYCLES);
    localparam rng_state_t      LOAD_ST   = (WARMUP_CYCLES == 0) ? SERVE : WARMUP;

    generate
        if (WIDTH != 8 && WIDTH != 16 && WIDTH != 32) begin : g_bad_width
            $error("rng_server: WIDTH must be 8, 16 or 32");
        end
    endgenerate

    rng_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_lfsr;
    logic [7:0]       r_cnt;
    logic [PW-1:0]    r_ptr;
    logic [N_REQ-1:0] r_gnt;
    logic             r_vld;
    logic [WIDTH-1:0] r_rnd;
    logic             r_ready;

    logic             w_arb_en;
    logic             w_warm_step;
    logic [N_REQ-1:0] w_gnt;
    logic [PW-1:0]    w_next_ptr;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_seed_s;
    logic [WIDTH-1:0] w_reseed_s;

    assign w_step     = WIDTH'(lfsr_step(32'(r_lfsr), WIDTH));
    assign w_seed_s   = WIDTH'(sanitize(32'(seed), WIDTH));
    assign w_reseed_s = WIDTH'(sanitize(32'(reseed_value), WIDTH));

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
        .i_req      (req),
        .i_enable   (w_arb_en),
        .i_ptr      (r_ptr),
        .o_gnt      (w_gnt),
        .o_next_ptr (w_next_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= LOAD_ST;
        else       r_state <= w_state_nxt;
    end

    // Warm-up ends on the cycle that takes the last discarded step.
    always_comb begin
        w_state_nxt = r_state;
        if (reseed)
            w_state_nxt = LOAD_ST;
        else if (r_state == WARMUP && r_cnt <= 8'd1)
            w_state_nxt = SERVE;
    end

    always_comb begin
        w_arb_en    = (r_state == SERVE) && !reseed;
        w_warm_step = (r_state == WARMUP) && !reseed && (r_cnt != 8'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr  <= w_seed_s;
            r_cnt   <= WARM_INIT;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_vld   <= 1'b0;
            r_rnd   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_gnt   <= w_gnt;
            r_vld   <= |w_gnt;
            r_ready <= (w_state_nxt == SERVE);
            if (reseed) begin
                r_lfsr <= w_reseed_s;
                r_cnt  <= WARM_INIT;
            end else if (w_warm_step) begin
                r_lfsr <= w_step;
                r_cnt  <= r_cnt - 8'd1;
            end else if (|w_gnt) begin
                r_rnd  <= r_lfsr;
                r_lfsr <= w_step;
                r_ptr  <= w_next_ptr;
            end
        end
    end

    assign gnt       = r_gnt;
    assign rnd_valid = r_vld;
    assign rnd_out   = r_rnd;
    assign ready     = r_ready;

endmodule
